// File: rtl/timer0_pkg.sv
// Shared definitions for the timer0 interrupt unit: FSM encoding, TIFR/TIMSK
// bit positions and the default ATmega32 vector addresses.
package timer0_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_CLEAR  = 2'd2,
    ST_SETTLE = 2'd3
  } state_e;

  localparam int OCF0  = 1;
  localparam int TOV0  = 0;
  localparam int OCIE0 = 1;
  localparam int TOIE0 = 0;

  localparam logic [15:0] DEF_COMP_VECTOR = 16'h0014;
  localparam logic [15:0] DEF_OVF_VECTOR  = 16'h0016;

  // Serviced source index maps directly onto its TIFR bit (1 = OCF0, 0 = TOV0).
  function automatic logic [7:0] clear_flag(input logic [7:0] tifr, input logic sel);
    return tifr & ~(8'h01 << sel);
  endfunction

endpackage

// File: rtl/timer0_interrupt_unit_if.sv
// CPU-side interrupt handshake: the unit (master) raises a request with its
// vector, the core (slave) answers with a single-cycle acknowledge.
interface timer0_interrupt_unit_if;
  logic        irq_request;
  logic [15:0] irq_vector;
  logic        irq_ack;

  modport master (output irq_request, output irq_vector, input irq_ack);
  modport slave  (input irq_request, input irq_vector, output irq_ack);
endinterface

// File: rtl/timer0_interrupt_unit.sv
// Timer0 interrupt unit: gates TIFR with TIMSK and SREG.I, requests the
// highest-priority source from the core and clears the serviced flag on ack.
module timer0_interrupt_unit
  import timer0_pkg::*;
#(
  parameter logic [15:0] COMP_VECTOR = DEF_COMP_VECTOR,
  parameter logic [15:0] OVF_VECTOR  = DEF_OVF_VECTOR
) (
  input  logic                           sysClock,
  input  logic                           reset_n,
  input  logic [7:0]                     TIFR_in,
  input  logic [7:0]                     TIMSK_in,
  input  logic                           SREG_I,
  input  logic                           timer_TIFR_we,
  timer0_interrupt_unit_if.master        cpu,
  output logic                           TIFR_write_enable,
  output logic [7:0]                     TIFR_write_data
);

  state_e      state_q, state_d;
  logic        sel_q, sel_d;
  logic        irq_request_q, irq_request_d;
  logic [15:0] irq_vector_q, irq_vector_d;
  logic        tifr_we_q, tifr_we_d;
  logic [7:0]  tifr_wdata_q, tifr_wdata_d;
  logic [1:0]  pending;
  logic        unused_timsk;

  assign unused_timsk = ^TIMSK_in[7:2];

  assign pending[1] = TIFR_in[OCF0] & TIMSK_in[OCIE0] & SREG_I;
  assign pending[0] = TIFR_in[TOV0] & TIMSK_in[TOIE0] & SREG_I;

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    tifr_we_d    = 1'b0;
    tifr_wdata_d = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (|pending) begin
          sel_d   = pending[1];
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // Once issued, the request is never re-targeted; it only completes or is withdrawn.
        if (cpu.irq_ack)             state_d = ST_CLEAR;
        else if (!pending[sel_q])    state_d = ST_IDLE;
      end
      ST_CLEAR: begin
        if (!timer_TIFR_we) begin
          tifr_we_d    = 1'b1;
          tifr_wdata_d = clear_flag(TIFR_in, sel_q);
          state_d      = ST_SETTLE;
        end
      end
      ST_SETTLE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so nothing reaches a pin combinationally.
    irq_request_d = (state_d == ST_REQ);
    irq_vector_d  = irq_request_d ? (sel_d ? COMP_VECTOR : OVF_VECTOR) : 16'h0000;
  end

  always_ff @(posedge sysClock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      sel_q         <= 1'b0;
      irq_request_q <= 1'b0;
      irq_vector_q  <= 16'h0000;
      tifr_we_q     <= 1'b0;
      tifr_wdata_q  <= 8'h00;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      irq_request_q <= irq_request_d;
      irq_vector_q  <= irq_vector_d;
      tifr_we_q     <= tifr_we_d;
      tifr_wdata_q  <= tifr_wdata_d;
    end
  end

  assign cpu.irq_request   = irq_request_q;
  assign cpu.irq_vector    = irq_vector_q;
  assign TIFR_write_enable = tifr_we_q;
  assign TIFR_write_data   = tifr_wdata_q;

endmodule

// File: tb/tb_timer0_interrupt_unit.sv
// Bench for timer0_interrupt_unit: directed scenarios plus randomized flag/mask
// combinations checked against a service-order model; TIFR is emulated here.
module tb_timer0_interrupt_unit;

  logic       sysClock = 1'b0;
  logic       reset_n  = 1'b0;
  logic [7:0] tifr     = 8'h00;
  logic [7:0] timsk    = 8'h00;
  logic       sreg     = 1'b0;
  logic       timer_we = 1'b0;
  logic       TIFR_write_enable;
  logic [7:0] TIFR_write_data;
  int         errs   = 0;
  int         checks = 0;

  timer0_interrupt_unit_if cpu_if();

  timer0_interrupt_unit #(.COMP_VECTOR(16'h0014), .OVF_VECTOR(16'h0016)) dut (
    .sysClock          (sysClock),
    .reset_n           (reset_n),
    .TIFR_in           (tifr),
    .TIMSK_in          (timsk),
    .SREG_I            (sreg),
    .timer_TIFR_we     (timer_we),
    .cpu               (cpu_if.master),
    .TIFR_write_enable (TIFR_write_enable),
    .TIFR_write_data   (TIFR_write_data)
  );

  always #5 sysClock = ~sysClock;

  // TIFR register: captures the strobe at the clock edge that ends the strobe cycle.
  always @(posedge sysClock) begin : tifr_emu
    logic [7:0] d;
    if (TIFR_write_enable) begin
      d = TIFR_write_data;
      #2 tifr = d;
    end
  end

  task automatic wait_req(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge sysClock);
      if (cpu_if.irq_request) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    cpu_if.irq_ack = 1'b0;
    @(negedge sysClock);
    checks++; if (cpu_if.irq_request !== 1'b0) begin errs++; $display("FAIL reset_req: got %b want 0", cpu_if.irq_request); end
    checks++; if (cpu_if.irq_vector !== 16'h0000) begin errs++; $display("FAIL reset_vec: got %h want 0000", cpu_if.irq_vector); end
    checks++; if (TIFR_write_enable !== 1'b0) begin errs++; $display("FAIL reset_we: got %b want 0", TIFR_write_enable); end
    checks++; if (TIFR_write_data !== 8'h00) begin errs++; $display("FAIL reset_wdata: got %h want 00", TIFR_write_data); end
    reset_n = 1'b1;
    repeat (2) @(negedge sysClock);
  endtask

  task automatic test_comp();
    int extra;
    tifr = 8'h02; timsk = 8'h02; sreg = 1'b1;
    @(negedge sysClock);
    checks++; if (cpu_if.irq_request !== 1'b1) begin errs++; $display("FAIL comp_latency: got req=%b want 1", cpu_if.irq_request); end
    checks++; if (cpu_if.irq_vector !== 16'h0014) begin errs++; $display("FAIL comp_vec: got %h want 0014", cpu_if.irq_vector); end
    cpu_if.irq_ack = 1'b1;
    @(negedge sysClock);
    cpu_if.irq_ack = 1'b0;
    checks++; if ({cpu_if.irq_request, TIFR_write_enable} !== 2'b00) begin errs++; $display("FAIL comp_clear_cycle: got req/we=%b want 00", {cpu_if.irq_request, TIFR_write_enable}); end
    @(negedge sysClock);
    checks++; if (TIFR_write_enable !== 1'b1) begin errs++; $display("FAIL comp_strobe: got %b want 1", TIFR_write_enable); end
    checks++; if (TIFR_write_data !== 8'h00) begin errs++; $display("FAIL comp_wdata: got %h want 00", TIFR_write_data); end
    extra = 0;
    repeat (6) begin
      @(negedge sysClock);
      if (cpu_if.irq_request || TIFR_write_enable) extra++;
    end
    checks++; if (extra !== 0) begin errs++; $display("FAIL comp_quiet_after: got %0d active cycles want 0", extra); end
    checks++; if (tifr !== 8'h00) begin errs++; $display("FAIL comp_tifr_cleared: got %h want 00", tifr); end
  endtask

  task automatic test_both();
    logic [15:0] vecs [4];
    logic [7:0]  dats [4];
    int          wcyc [4];
    int          nreq, nwr;
    bit          prev;
    nreq = 0; nwr = 0; prev = 1'b0;
    tifr = 8'h03; timsk = 8'h03; sreg = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge sysClock);
      if (cpu_if.irq_request && !prev && nreq < 4) begin vecs[nreq] = cpu_if.irq_vector; nreq++; end
      if (TIFR_write_enable && nwr < 4) begin dats[nwr] = TIFR_write_data; wcyc[nwr] = c; nwr++; end
      prev = cpu_if.irq_request;
      cpu_if.irq_ack = cpu_if.irq_request;
    end
    cpu_if.irq_ack = 1'b0;
    checks++; if (nreq !== 2) begin errs++; $display("FAIL both_nreq: got %0d want 2", nreq); end
    checks++; if (nwr !== 2) begin errs++; $display("FAIL both_nwr: got %0d want 2", nwr); end
    if (nreq >= 2) begin
      checks++; if (vecs[0] !== 16'h0014) begin errs++; $display("FAIL both_vec0: got %h want 0014", vecs[0]); end
      checks++; if (vecs[1] !== 16'h0016) begin errs++; $display("FAIL both_vec1: got %h want 0016", vecs[1]); end
    end
    if (nwr >= 2) begin
      checks++; if (dats[0] !== 8'h01) begin errs++; $display("FAIL both_wdata0: got %h want 01", dats[0]); end
      checks++; if (dats[1] !== 8'h00) begin errs++; $display("FAIL both_wdata1: got %h want 00", dats[1]); end
      checks++; if (wcyc[1] - wcyc[0] !== 4) begin errs++; $display("FAIL both_spacing: got %0d want 4", wcyc[1] - wcyc[0]); end
    end
  endtask

  task automatic test_masked();
    int act;
    tifr = 8'h01; timsk = 8'h00; sreg = 1'b1;
    act = 0;
    repeat (10) begin @(negedge sysClock); if (cpu_if.irq_request || TIFR_write_enable) act++; end
    checks++; if (act !== 0) begin errs++; $display("FAIL masked_timsk: got %0d active cycles want 0", act); end
    timsk = 8'h01; sreg = 1'b0;
    act = 0;
    repeat (10) begin @(negedge sysClock); if (cpu_if.irq_request || TIFR_write_enable) act++; end
    checks++; if (act !== 0) begin errs++; $display("FAIL masked_sreg: got %0d active cycles want 0", act); end
    tifr = 8'h00; timsk = 8'h00;
    repeat (2) @(negedge sysClock);
  endtask

  task automatic test_drop();
    bit ok;
    int wr;
    tifr = 8'h01; timsk = 8'h01; sreg = 1'b1;
    wait_req(5, ok);
    checks++; if (ok !== 1'b1) begin errs++; $display("FAIL drop_req_timeout: got %b want 1", ok); end
    checks++; if (cpu_if.irq_vector !== 16'h0016) begin errs++; $display("FAIL drop_vec: got %h want 0016", cpu_if.irq_vector); end
    timsk = 8'h00;
    @(negedge sysClock);
    checks++; if (cpu_if.irq_request !== 1'b0) begin errs++; $display("FAIL drop_req_fall: got %b want 0", cpu_if.irq_request); end
    wr = 0;
    repeat (8) begin @(negedge sysClock); if (TIFR_write_enable) wr++; end
    checks++; if (wr !== 0) begin errs++; $display("FAIL drop_no_write: got %0d writes want 0", wr); end
    checks++; if (tifr !== 8'h01) begin errs++; $display("FAIL drop_tifr_kept: got %h want 01", tifr); end
    tifr = 8'h00;
    repeat (2) @(negedge sysClock);
  endtask

  task automatic test_collision();
    bit ok;
    tifr = 8'h03; timsk = 8'h01; sreg = 1'b1;
    wait_req(5, ok);
    checks++; if (ok !== 1'b1 || cpu_if.irq_vector !== 16'h0016) begin errs++; $display("FAIL coll_req: got ok=%b vec=%h want 1/0016", ok, cpu_if.irq_vector); end
    cpu_if.irq_ack = 1'b1;
    @(negedge sysClock);
    cpu_if.irq_ack = 1'b0;
    timer_we = 1'b1; tifr = 8'h83;
    @(negedge sysClock);
    checks++; if (TIFR_write_enable !== 1'b0) begin errs++; $display("FAIL coll_suppress1: got %b want 0", TIFR_write_enable); end
    @(negedge sysClock);
    checks++; if (TIFR_write_enable !== 1'b0) begin errs++; $display("FAIL coll_suppress2: got %b want 0", TIFR_write_enable); end
    timer_we = 1'b0;
    @(negedge sysClock);
    checks++; if (TIFR_write_enable !== 1'b1) begin errs++; $display("FAIL coll_strobe: got %b want 1", TIFR_write_enable); end
    checks++; if (TIFR_write_data !== 8'h82) begin errs++; $display("FAIL coll_wdata: got %h want 82", TIFR_write_data); end
    @(negedge sysClock);
    checks++; if (TIFR_write_enable !== 1'b0) begin errs++; $display("FAIL coll_single: got %b want 0", TIFR_write_enable); end
    tifr = 8'h00; timsk = 8'h00;
    repeat (3) @(negedge sysClock);
  endtask

  task automatic test_reset_mid();
    bit ok;
    tifr = 8'h02; timsk = 8'h02; sreg = 1'b1;
    wait_req(5, ok);
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({cpu_if.irq_request, cpu_if.irq_vector} !== 17'h0) begin errs++; $display("FAIL rst_req_async: got req=%b vec=%h want 0/0000", cpu_if.irq_request, cpu_if.irq_vector); end
    @(negedge sysClock);
    reset_n = 1'b1;
    wait_req(5, ok);
    checks++; if (ok !== 1'b1 || cpu_if.irq_vector !== 16'h0014) begin errs++; $display("FAIL rst_rerequest: got ok=%b vec=%h want 1/0014", ok, cpu_if.irq_vector); end
    cpu_if.irq_ack = 1'b1;
    @(negedge sysClock);
    cpu_if.irq_ack = 1'b0;
    timer_we = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({cpu_if.irq_request, TIFR_write_enable, TIFR_write_data} !== 10'h0) begin errs++; $display("FAIL rst_clear_async: got req=%b we=%b data=%h want 0", cpu_if.irq_request, TIFR_write_enable, TIFR_write_data); end
    @(negedge sysClock);
    reset_n = 1'b1; timer_we = 1'b0;
    wait_req(5, ok);
    checks++; if (ok !== 1'b1 || tifr !== 8'h02) begin errs++; $display("FAIL rst_no_clear: got ok=%b tifr=%h want 1/02", ok, tifr); end
    cpu_if.irq_ack = 1'b1;
    @(negedge sysClock);
    cpu_if.irq_ack = 1'b0;
    @(negedge sysClock);
    checks++; if (TIFR_write_enable !== 1'b1 || TIFR_write_data !== 8'h00) begin errs++; $display("FAIL rst_final_clear: got we=%b data=%h want 1/00", TIFR_write_enable, TIFR_write_data); end
    tifr = 8'h00; timsk = 8'h00;
    repeat (3) @(negedge sysClock);
  endtask

  task automatic test_random();
    int         q[$];
    logic [7:0] t, m, model, expd;
    logic       s;
    bit         prev;
    int         dly;
    for (int it = 0; it < 25; it++) begin
      t = 8'($urandom); m = 8'($urandom); s = ($urandom % 4) != 0;
      q.delete();
      // Service order: COMP first if enabled, then OVF; each clears only its own bit.
      if (t[1] && m[1] && s) q.push_back(1);
      if (t[0] && m[0] && s) q.push_back(0);
      model = t; prev = 1'b0; dly = 0;
      tifr = t; timsk = m; sreg = s;
      for (int c = 0; c < 50; c++) begin
        @(negedge sysClock);
        cpu_if.irq_ack = 1'b0;
        timer_we = ($urandom % 4) == 0;
        if (TIFR_write_enable) begin
          checks++;
          if (q.size() == 0) begin errs++; $display("FAIL rnd_extra_write it=%0d: got data=%h want no write", it, TIFR_write_data); end
          else begin
            expd = model & ~(8'h01 << q[0]);
            if (TIFR_write_data !== expd) begin errs++; $display("FAIL rnd_wdata it=%0d: got %h want %h", it, TIFR_write_data, expd); end
            model = expd;
            void'(q.pop_front());
          end
        end
        if (cpu_if.irq_request && !prev) begin
          checks++;
          if (q.size() == 0) begin errs++; $display("FAIL rnd_extra_req it=%0d: got vec=%h want no request", it, cpu_if.irq_vector); end
          else if (cpu_if.irq_vector !== (q[0] == 1 ? 16'h0014 : 16'h0016)) begin
            errs++; $display("FAIL rnd_vec it=%0d: got %h want %h", it, cpu_if.irq_vector, (q[0] == 1 ? 16'h0014 : 16'h0016));
          end
          dly = $urandom % 3;
        end
        if (cpu_if.irq_request) begin
          if (dly == 0) cpu_if.irq_ack = 1'b1;
          else dly--;
        end else if ($urandom % 5 == 0) begin
          cpu_if.irq_ack = 1'b1;
        end
        prev = cpu_if.irq_request;
      end
      checks++; if (q.size() !== 0) begin errs++; $display("FAIL rnd_unserviced it=%0d: got %0d left want 0", it, q.size()); end
      cpu_if.irq_ack = 1'b0; timer_we = 1'b0; tifr = 8'h00;
      repeat (4) @(negedge sysClock);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_comp();
    test_both();
    test_masked();
    test_drop();
    test_collision();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
